load_cell_a2d: RTL and testbench
================================

LOAD_CELL_A2D -- requirements
Module: load_cell_a2d

Interface
REQ-001 Parameter CH_LFT, default 3'd0: A2D channel of left load cell.
REQ-002 Parameter CH_RGHT, default 3'd4: A2D channel of right load cell.
REQ-003 Parameter CH_STEER, default 3'd5: A2D channel of steering pot.
REQ-004 Parameter CH_BATT, default 3'd6: A2D channel of battery divider.
REQ-005 Port clk, input, 1: system clock; all state changes on posedge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port nxt, input, 1: single-cycle request to start the next round-robin conversion.
REQ-008 Port MISO, input, 1: serial data from A2D.
REQ-009 Port SS_n, output, 1: active-low A2D select.
REQ-010 Port SCLK, output, 1: serial clock, clk/32, idles high.
REQ-011 Port MOSI, output, 1: serial command to A2D.
REQ-012 Port lft_ld, output, 12: latest left load-cell reading, unsigned.
REQ-013 Port rght_ld, output, 12: latest right load-cell reading, unsigned.
REQ-014 Port steer_pot, output, 12: latest steering pot reading, unsigned.
REQ-015 Port batt, output, 12: latest battery reading, unsigned.
REQ-016 Port cnv_cmplt, output, 1: one-cycle pulse when a result register updates.

Function
REQ-017 Channels SHALL be converted in fixed order lft -> rght -> steer -> batt -> lft, one channel per accepted nxt.
REQ-018 States SHALL be IDLE, TX1, GAP, TX2, DONE: IDLE--nxt-->TX1--520 clk-->GAP--32 clk-->TX2--520 clk-->DONE--1 clk-->IDLE.
REQ-019 nxt SHALL be ignored in every state except IDLE; no queuing.
REQ-020 Each transaction SHALL hold SS_n low exactly 520 clk: first SCLK fall 8 clk after SS_n falls, SCLK period 32 clk (16 low, 16 high), 16 rising edges, SS_n rising 16 clk after the 16th rise.
REQ-021 MOSI SHALL change only on SCLK falling edges, MSB first; MOSI SHALL be 0 whenever SS_n is high.
REQ-022 MISO SHALL be sampled into a 16-bit shift register on each SCLK rising edge.
REQ-023 TX1 SHALL send command {2'b00, ch[2:0], 11'h000} for the current channel; data received in TX1 SHALL be discarded.
REQ-024 TX2 SHALL send 16'h0000; the result SHALL be the low 12 bits of the TX2 shift register.
REQ-025 SS_n SHALL be high for exactly 32 clk in GAP.
REQ-026 In DONE, only the selected channel's output register SHALL update; the other three SHALL hold.
REQ-027 cnv_cmplt SHALL pulse high for exactly 1 clk, coinciding with the DONE update.
REQ-028 The channel pointer SHALL advance in DONE, wrapping batt -> lft.
REQ-029 Latency from nxt sampled in IDLE to cnv_cmplt SHALL be 1074 clk (1 + 520 + 32 + 520 + 1).
REQ-030 The SCLK divider and bit counter SHALL reset at the start of each transaction; no partial-bit carry-over.
REQ-031 nxt asserted in the DONE cycle SHALL be ignored; nxt in the following IDLE cycle SHALL be accepted.

Reset
REQ-032 On rst, all outputs SHALL take reset values asynchronously: SS_n=1, SCLK=1, MOSI=0, lft_ld=rght_ld=steer_pot=batt=12'h000, cnv_cmplt=0.
REQ-033 On rst, state SHALL be IDLE and the channel pointer SHALL point at lft.
REQ-034 Reset mid-transaction SHALL abort immediately with no output register update; the next nxt after release SHALL restart at lft.

Verification
REQ-035 Single nxt, A2D model returns 12'hA5C on ch0 -> TX1 MOSI command 16'h0000; lft_ld=12'hA5C; cnv_cmplt exactly 1074 clk after nxt; other outputs remain 0.
REQ-036 Four nxt pulses, model returns 12'h111/12'h222/12'h333/12'h444 -> commands carry ch 0, 4, 5, 6; lft_ld=111, rght_ld=222, steer_pot=333, batt=444; fifth nxt reads ch0 again.
REQ-037 SPI timing check, single conversion -> SS_n low 520 clk twice, high 32 clk between, 16 SCLK rises per frame, SCLK high whenever SS_n is high, no MOSI change on SCLK rise.
REQ-038 nxt pulsed every 100 clk while busy -> exactly one conversion per 1074-clk window; extra pulses produce no extra cnv_cmplt.
REQ-039 rst at clk 300 of TX2 for rght (lft_ld=12'h0F0 already) -> SS_n=1, SCLK=1 same cycle; all outputs 0; next nxt sends ch0 command.
REQ-040 Model drives MISO upper nibble 4'hF with value 12'h800 -> rght_ld=12'h800; upper nibble discarded.

Source files
------------

// File: rtl/load_cell_a2d.sv
`default_nettype none
// ============================================================================
// Module  : load_cell_a2d
// Purpose : Round-robin SPI A2D reader for two load cells, steer pot, battery.
// Revision: 1.0
// ============================================================================
module load_cell_a2d #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TX1  = 3'd1,
    GAP  = 3'd2,
    TX2  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [9:0] C_FRAME_LAST = 10'd519;
  localparam logic [9:0] C_GAP_LAST   = 10'd31;
  localparam logic [9:0] C_LEAD       = 10'd8;

  state_t      r_state;
  logic [9:0]  r_cnt;
  logic [1:0]  r_ptr;
  logic [15:0] r_tx;
  logic [11:0] r_rx;
  logic        r_ss_n;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_cnv_cmplt;
  logic [11:0] r_lft;
  logic [11:0] r_rght;
  logic [11:0] r_steer;
  logic [11:0] r_batt;

  logic [9:0]  w_cnt_inc;
  logic [4:0]  w_ph;
  logic        w_fall;
  logic        w_rise;
  logic [2:0]  w_ch;

  // SCLK phase is referenced to the first falling edge, 8 clk into the frame
  assign w_cnt_inc = r_cnt + 10'd1;
  assign w_ph      = w_cnt_inc[4:0] - 5'd8;
  assign w_fall    = (w_cnt_inc >= C_LEAD) && (w_ph == 5'd0);
  assign w_rise    = (w_cnt_inc >= C_LEAD) && (w_ph == 5'd16);

  always_comb begin
    w_ch = CH_LFT;
    case (r_ptr)
      2'd0:    w_ch = CH_LFT;
      2'd1:    w_ch = CH_RGHT;
      2'd2:    w_ch = CH_STEER;
      default: w_ch = CH_BATT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= 2'd0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_ss_n      <= 1'b1;
      r_sclk      <= 1'b1;
      r_mosi      <= 1'b0;
      r_cnv_cmplt <= 1'b0;
      r_lft       <= '0;
      r_rght      <= '0;
      r_steer     <= '0;
      r_batt      <= '0;
    end else begin
      r_cnv_cmplt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (nxt) begin
            r_state <= TX1;
            r_ss_n  <= 1'b0;
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_mosi  <= 1'b0;
            r_tx    <= {2'b00, w_ch, 11'h000};
            r_rx    <= '0;
          end
        end
        TX1, TX2: begin
          if (r_cnt == C_FRAME_LAST) begin
            r_state <= (r_state == TX1) ? GAP : DONE;
            r_ss_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_fall) begin
              r_sclk <= 1'b0;
              r_mosi <= r_tx[15];
              r_tx   <= {r_tx[14:0], 1'b0};
            end
            // only the last 12 bits shifted in survive; the upper nibble falls out
            if (w_rise) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[10:0], MISO};
            end
          end
        end
        GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_state <= TX2;
            r_ss_n  <= 1'b0;
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_mosi  <= 1'b0;
            r_tx    <= 16'h0000;
            r_rx    <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DONE: begin
          case (r_ptr)
            2'd0:    r_lft   <= r_rx;
            2'd1:    r_rght  <= r_rx;
            2'd2:    r_steer <= r_rx;
            default: r_batt  <= r_rx;
          endcase
          r_cnv_cmplt <= 1'b1;
          r_ptr       <= r_ptr + 2'd1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign SS_n      = r_ss_n;
  assign SCLK      = r_sclk;
  assign MOSI      = r_mosi;
  assign lft_ld    = r_lft;
  assign rght_ld   = r_rght;
  assign steer_pot = r_steer;
  assign batt      = r_batt;
  assign cnv_cmplt = r_cnv_cmplt;

endmodule
`default_nettype wire

// File: tb/tb_load_cell_a2d.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_cell_a2d
// Purpose : Randomized bench with A2D slave model and conversion scoreboard.
// Revision: 1.0
// ============================================================================
module tb_load_cell_a2d;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, cnv_cmplt;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  always #5 clk = ~clk;

  load_cell_a2d dut (
    .clk(clk), .rst(rst), .nxt(nxt), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .cnv_cmplt(cnv_cmplt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: value per A2D channel, expected outputs, pending completions
  typedef struct {
    int          cyc;
    int          idx;
    logic [11:0] v;
  } done_t;

  logic [11:0] val [8];
  logic [11:0] exp_out [4];
  int          ch_order [4] = '{0, 4, 5, 6};
  int          ptr = 0;
  int          free_cyc = 0;
  int          gc = 0;
  done_t       pend [$];
  logic [15:0] cmd_q [$];
  logic        force_f = 1'b0;

  // A2D slave: answers with the channel named in the previous frame's command
  logic [15:0] resp, cmd_in;
  int          bidx, rises;
  logic [2:0]  last_ch = 3'd0;
  logic        m_ss = 1'b1, m_sclk = 1'b1;
  logic [3:0]  nib;

  always @(SS_n, SCLK) begin
    if (SS_n !== m_ss) begin
      if (SS_n === 1'b0) begin
        nib    = force_f ? 4'hF : 4'($urandom_range(0, 15));
        resp   = {nib, val[last_ch]};
        bidx   = 0;
        rises  = 0;
        cmd_in = '0;
      end else if (SS_n === 1'b1 && m_ss === 1'b0 && rst === 1'b0) begin
        check_val("sclk_rises", rises, 16);
        check_val("cmd_pending", cmd_q.size() > 0, 1);
        if (cmd_q.size() > 0) check_val("mosi_cmd", cmd_in, cmd_q.pop_front());
        last_ch = cmd_in[13:11];
      end
      m_ss = SS_n;
    end
    if (SCLK !== m_sclk) begin
      if (SS_n === 1'b0) begin
        if (SCLK === 1'b0 && bidx < 16) MISO = resp[15-bidx];
        else if (SCLK === 1'b1 && m_sclk === 1'b0) begin
          cmd_in = {cmd_in[14:0], MOSI};
          bidx++;
          rises++;
        end
      end
      m_sclk = SCLK;
    end
  end

  // SPI framing monitor
  int   low_run = 0, high_run = 0;
  logic frame_par = 1'b0, p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      low_run = 0; high_run = 0; frame_par = 1'b0;
      p_ss = 1'b1; p_sclk = 1'b1; p_mosi = 1'b0;
    end else begin
      if (SS_n) begin
        check_val("sclk_idle", SCLK, 1'b1);
        check_val("mosi_idle", MOSI, 1'b0);
      end
      if (!SS_n && !p_ss && MOSI !== p_mosi)
        check_val("mosi_edge", {30'b0, p_sclk, SCLK}, 32'd2);
      if (!SS_n) begin
        if (p_ss) begin
          if (frame_par) check_val("gap_len", high_run, 32);
          low_run = 1;
        end else low_run++;
      end else begin
        if (!p_ss) begin
          check_val("ss_low_len", low_run, 520);
          frame_par = ~frame_par;
          high_run = 1;
        end else high_run++;
      end
      p_ss = SS_n; p_sclk = SCLK; p_mosi = MOSI;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    nxt = 1'b0;
    #1;
    check_val("rst_ss_n", SS_n, 1'b1);
    check_val("rst_sclk", SCLK, 1'b1);
    check_val("rst_mosi", MOSI, 1'b0);
    check_val("rst_lft", lft_ld, 12'h000);
    check_val("rst_rght", rght_ld, 12'h000);
    check_val("rst_steer", steer_pot, 12'h000);
    check_val("rst_batt", batt, 12'h000);
    check_val("rst_cnv", cnv_cmplt, 1'b0);
    pend.delete();
    cmd_q.delete();
    ptr = 0;
    free_cyc = 0;
    for (int i = 0; i < 4; i++) exp_out[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode: 1 single pulse, 2 every 100 clk, 3 random, 4 pulses at 0/1073/1074
  task automatic run(input int n, input int mode);
    logic exp_c, p;
    int   ch;
    for (int r = 0; r < n; r++) begin
      @(posedge clk); #1;
      exp_c = (pend.size() > 0) && (pend[0].cyc == gc);
      if (exp_c) begin
        exp_out[pend[0].idx] = pend[0].v;
        void'(pend.pop_front());
      end
      if (cnv_cmplt || exp_c) check_val("cnv_cmplt", cnv_cmplt, exp_c);
      check_val("lft_ld", lft_ld, exp_out[0]);
      check_val("rght_ld", rght_ld, exp_out[1]);
      check_val("steer_pot", steer_pot, exp_out[2]);
      check_val("batt", batt, exp_out[3]);
      case (mode)
        1:       p = (r == 0);
        2:       p = (r % 100 == 0) && (r + 1100 < n);
        3:       p = ($urandom_range(0, 99) < 2) && (r + 1100 < n);
        4:       p = (r == 0) || (r == 1073) || (r == 1074);
        default: p = 1'b0;
      endcase
      nxt = p;
      if (p && gc >= free_cyc) begin
        ch = ch_order[ptr];
        cmd_q.push_back({2'b00, 3'(ch), 11'h000});
        cmd_q.push_back(16'h0000);
        pend.push_back('{gc + 1074, ptr, val[ch]});
        free_cyc = gc + 1074;
        ptr = (ptr + 1) % 4;
      end
      gc++;
    end
    nxt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) val[i] = '0;
    for (int i = 0; i < 4; i++) exp_out[i] = '0;
    do_reset();

    val[0] = 12'hA5C;
    run(1200, 1);

    do_reset();
    val[0] = 12'h111; val[4] = 12'h222; val[5] = 12'h333; val[6] = 12'h444;
    repeat (5) run(1100, 1);

    do_reset();
    force_f = 1'b1;
    val[4] = 12'h800;
    run(1100, 1);
    run(1100, 1);
    force_f = 1'b0;

    for (int i = 0; i < 8; i++) val[i] = 12'($urandom_range(0, 4095));
    run(2400, 2);
    run(2300, 4);
    for (int i = 0; i < 8; i++) val[i] = 12'($urandom_range(0, 4095));
    run(6000, 3);

    // abort 300 clk into the TX2 frame of the rght conversion
    do_reset();
    val[0] = 12'h0F0;
    run(1100, 1);
    run(853, 1);
    do_reset();
    run(1100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
